// File: rtl/nn_vpu.sv
// nn_vpu: post-processing unit for systolic-array column outputs.
// Per lane: saturating bias add, then leaky ReLU, then a deskew FIFO. Lanes are popped
// together as one aligned vector that feeds an output register (valid/ready handshake)
// and/or a one-cycle feedback pulse back to the accumulators.
module nn_vpu #(
  parameter int LANES = 2,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_bias_en,
  input  logic                   cfg_act_en,
  input  logic [LANES*WIDTH-1:0] bias_in,
  input  logic [WIDTH-1:0]       leak_factor,
  input  logic [LANES-1:0]       lane_valid_in,
  input  logic [LANES*WIDTH-1:0] lane_data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   fb_valid,
  output logic [LANES*WIDTH-1:0] fb_data,
  output logic                   busy,
  output logic                   overrun
);

  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PROD_W = 2 * WIDTH;

  localparam logic signed [PROD_W-1:0] SatMax = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SatMin = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  function automatic logic signed [PROD_W-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [PROD_W-1:0] v);
    logic signed [PROD_W-1:0] r;
    if (v > SatMax) r = SatMax;
    else if (v < SatMin) r = SatMin;
    else r = v;
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] leaky(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] leak,
                                            input logic act);
    logic signed [PROD_W-1:0] prod;
    if (!act || !x[WIDTH-1]) return x;
    prod = sext(x) * sext(leak);
    return sat(prod >>> FRAC);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [LANES-1:0] s1_valid_q, s1_act_q, s2_valid_q;
  logic [WIDTH-1:0] s1_data_q [LANES];
  logic [WIDTH-1:0] s2_data_q [LANES];
  logic [WIDTH-1:0] mem_q     [LANES][DEPTH];
  logic [PW-1:0]    wr_ptr_q  [LANES];
  logic [PW-1:0]    rd_ptr_q  [LANES];
  logic [CW-1:0]    count_q   [LANES];

  logic [LANES-1:0]       nonempty, full, push_ok;
  logic                   pop;
  logic [LANES*WIDTH-1:0] pop_vec;
  logic                   out_valid_q, fb_valid_q, overrun_q;
  logic [LANES*WIDTH-1:0] out_data_q, fb_data_q;

  // Stages 1 and 2: bias add then activation. Act enable travels with the data so a config
  // change never reprocesses a value already in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= '0;
      s1_act_q   <= '0;
      s2_valid_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_data_q[i] <= '0;
        s2_data_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= lane_valid_in;
      s2_valid_q <= s1_valid_q;
      for (int i = 0; i < LANES; i++) begin
        if (lane_valid_in[i]) begin
          s1_data_q[i] <= sat(sext(lane_data_in[i*WIDTH +: WIDTH]) +
                              (cfg_bias_en ? sext(bias_in[i*WIDTH +: WIDTH]) : '0));
          s1_act_q[i]  <= cfg_act_en;
        end
        if (s1_valid_q[i]) s2_data_q[i] <= leaky(s1_data_q[i], leak_factor, s1_act_q[i]);
      end
    end
  end

  // FIFO status, push acceptance and the all-lanes vector pop decision.
  always_comb begin
    pop_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      nonempty[i] = (count_q[i] != '0);
      full[i]     = (count_q[i] == CW'(DEPTH));
      pop_vec[i*WIDTH +: WIDTH] = mem_q[i][rd_ptr_q[i]];
    end
    pop = (&nonempty) && (!cfg_mode[1] || !out_valid_q || out_ready);
    for (int i = 0; i < LANES; i++) begin
      // A full FIFO still accepts a push when it pops on the same edge.
      push_ok[i] = s2_valid_q[i] && (!full[i] || pop);
    end
  end

  // FIFO storage; contents need no reset since counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= s2_data_q[i];
    end
  end

  // FIFO pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push_ok[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        if (pop) rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        if (push_ok[i] && !pop) count_q[i] <= count_q[i] + 1'b1;
        else if (!push_ok[i] && pop) count_q[i] <= count_q[i] - 1'b1;
        if (s2_valid_q[i] && !push_ok[i]) overrun_q <= 1'b1;
      end
    end
  end

  // Output register with handshake and the one-cycle feedback pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      fb_valid_q  <= 1'b0;
      fb_data_q   <= '0;
    end else begin
      if (pop && cfg_mode[1]) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pop_vec;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      fb_valid_q <= pop && cfg_mode[0];
      if (pop && cfg_mode[0]) fb_data_q <= pop_vec;
    end
  end

  // Busy while any stage, FIFO or output register holds data.
  always_comb begin
    busy = (|s1_valid_q) || (|s2_valid_q) || (|nonempty) || out_valid_q || fb_valid_q;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign fb_valid  = fb_valid_q;
  assign fb_data   = fb_data_q;
  assign overrun   = overrun_q;

endmodule
